// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int IW        = 9;
    localparam int AW        = 9;
    localparam int TW        = 8;
    localparam int LUT_DEPTH = 32;
    localparam int LW        = $clog2(LUT_DEPTH);

    localparam logic [2:0] BR_OPCODE = 3'b111;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        FETCH   = 3'd2,
        ISSUE   = 3'd3,
        ADVANCE = 3'd4,
        HALT    = 3'd5
    } state_t;

    function automatic logic is_branch(input logic [IW-1:0] ins);
        return (ins[IW-1:IW-3] == BR_OPCODE);
    endfunction

endpackage

// File: rtl/jump_lut.sv
// Combinational ROM of branch offsets, indexed by the low instruction bits.
module jump_lut
    import fetch_pkg::*;
(
    input  logic [LW-1:0] index_i,
    output logic [TW-1:0] offset_o
);

    // offset table lookup
    always_comb begin
        offset_o = {TW{1'b0}};
        case (index_i)
            5'd0:    offset_o = 8'd1;
            5'd1:    offset_o = 8'd2;
            5'd2:    offset_o = 8'd3;
            5'd3:    offset_o = 8'd5;
            5'd4:    offset_o = 8'd8;
            5'd5:    offset_o = 8'd13;
            5'd6:    offset_o = 8'd21;
            5'd7:    offset_o = 8'd34;
            5'd8:    offset_o = 8'd55;
            5'd9:    offset_o = 8'd89;
            5'd10:   offset_o = 8'd144;
            5'd11:   offset_o = 8'd233;
            5'd12:   offset_o = 8'd7;
            5'd13:   offset_o = 8'd0;
            5'd14:   offset_o = 8'd255;
            5'd15:   offset_o = 8'd128;
            5'd16:   offset_o = 8'd64;
            5'd17:   offset_o = 8'd32;
            5'd18:   offset_o = 8'd16;
            5'd19:   offset_o = 8'd4;
            5'd20:   offset_o = 8'd9;
            5'd21:   offset_o = 8'd17;
            5'd22:   offset_o = 8'd33;
            5'd23:   offset_o = 8'd65;
            5'd24:   offset_o = 8'd129;
            5'd25:   offset_o = 8'd200;
            5'd26:   offset_o = 8'd100;
            5'd27:   offset_o = 8'd50;
            5'd28:   offset_o = 8'd25;
            5'd29:   offset_o = 8'd12;
            5'd30:   offset_o = 8'd6;
            5'd31:   offset_o = 8'd3;
            default: offset_o = {TW{1'b0}};
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: reads the instruction at the PC, holds it for the datapath,
// then pulses next_ins with the branch decision so the PC can advance.
module fetch_sequencer
    import fetch_pkg::*;
(
    input  logic          clock_i,
    input  logic          reset_n_i,
    input  logic          start_i,
    input  logic          pc_done_i,
    input  logic [AW-1:0] pc_i,
    output logic [AW-1:0] imem_addr_o,
    input  logic [IW-1:0] imem_rdata_i,
    output logic [IW-1:0] instr_o,
    output logic          instr_valid_o,
    input  logic          exec_done_i,
    input  logic          cond_flag_i,
    output logic          next_ins_o,
    output logic          jump_flag_o,
    output logic [TW-1:0] target_o,
    output logic          running_o
);

    state_t        state_q;
    logic [IW-1:0] instr_q;
    logic          valid_q;
    logic          next_ins_q;
    logic          jump_q;
    logic [TW-1:0] target_q;
    logic          running_q;

    logic [TW-1:0] lut_offset_s;
    logic          jump_d;
    logic [TW-1:0] target_d;

    jump_lut u_jump_lut (
        .index_i  (instr_q[LW-1:0]),
        .offset_o (lut_offset_s)
    );

    // branch decision captured on the exec_done edge; not-taken forces a zero offset
    always_comb begin
        jump_d = is_branch(instr_q) & cond_flag_i;
        if (jump_d) begin
            target_d = lut_offset_s;
        end else begin
            target_d = {TW{1'b0}};
        end
    end

    assign imem_addr_o = pc_i;

    // sequencer FSM; start overrides every state, running survives a mid-program restart
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            instr_q    <= {IW{1'b0}};
            valid_q    <= 1'b0;
            next_ins_q <= 1'b0;
            jump_q     <= 1'b0;
            target_q   <= {TW{1'b0}};
            running_q  <= 1'b0;
        end else if (start_i) begin
            state_q    <= SYNC;
            valid_q    <= 1'b0;
            next_ins_q <= 1'b0;
            jump_q     <= 1'b0;
            target_q   <= {TW{1'b0}};
        end else begin
            case (state_q)
                IDLE: state_q <= IDLE;
                SYNC: begin
                    state_q   <= FETCH;
                    running_q <= 1'b1;
                end
                FETCH: begin
                    if (pc_done_i) begin
                        state_q   <= HALT;
                        running_q <= 1'b0;
                    end else begin
                        state_q <= ISSUE;
                        instr_q <= imem_rdata_i;
                        valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (exec_done_i) begin
                        state_q    <= ADVANCE;
                        valid_q    <= 1'b0;
                        next_ins_q <= 1'b1;
                        jump_q     <= jump_d;
                        target_q   <= target_d;
                    end
                end
                ADVANCE: begin
                    state_q    <= FETCH;
                    next_ins_q <= 1'b0;
                    jump_q     <= 1'b0;
                    target_q   <= {TW{1'b0}};
                end
                HALT: state_q <= HALT;
                default: begin
                    state_q    <= IDLE;
                    valid_q    <= 1'b0;
                    next_ins_q <= 1'b0;
                    jump_q     <= 1'b0;
                    target_q   <= {TW{1'b0}};
                    running_q  <= 1'b0;
                end
            endcase
        end
    end

    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign next_ins_o    = next_ins_q;
    assign jump_flag_o   = jump_q;
    assign target_o      = target_q;
    assign running_o     = running_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed cycle table, reset sequence, and randomized
// programs checked against an instruction-level model of the fetch/branch rules.
module tb_fetch_sequencer;

    logic       clock, reset_n, start, pc_done, exec_done, cond_flag;
    logic [8:0] pc_q, imem_addr, imem_rdata, instr;
    logic       instr_valid, next_ins, jump_flag, running;
    logic [7:0] target;

    logic [8:0] mem [0:511];
    logic [7:0] lut_ref [0:31];
    logic [8:0] start_addr, done_addr;

    int errors = 0;
    int checks = 0;

    fetch_sequencer dut (
        .clock_i       (clock),
        .reset_n_i     (reset_n),
        .start_i       (start),
        .pc_done_i     (pc_done),
        .pc_i          (pc_q),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .exec_done_i   (exec_done),
        .cond_flag_i   (cond_flag),
        .next_ins_o    (next_ins),
        .jump_flag_o   (jump_flag),
        .target_o      (target),
        .running_o     (running)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // read data settles within the FETCH cycle
    assign imem_rdata = mem[imem_addr];

    // program counter model driven by the sequencer outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)      pc_q <= 9'd0;
        else if (start)    pc_q <= start_addr;
        else if (next_ins) pc_q <= pc_q + 9'd1 + (jump_flag ? {1'b0, target} : 9'd0);
    end
    assign pc_done = (pc_q == done_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       st;  logic [8:0] sa; logic ex; logic cd;
        logic       v;   logic ni; logic jf; logic [7:0] tg; logic run;
        logic [8:0] ad;  logic [8:0] ins;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic [8:0] sa, logic ex, logic cd, logic v, logic ni,
                                logic jf, logic [7:0] tg, logic run, logic [8:0] ad, logic [8:0] ins);
        vec_t r;
        r.st = st; r.sa = sa; r.ex = ex; r.cd = cd; r.v = v; r.ni = ni;
        r.jf = jf; r.tg = tg; r.run = run; r.ad = ad; r.ins = ins;
        return r;
    endfunction

    logic [8:0] arch_pc, cur;
    logic [7:0] tgt;
    logic       taken, exp_adv, halted;
    int         gap;

    initial begin
        lut_ref = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34,
                    8'd55, 8'd89, 8'd144, 8'd233, 8'd7, 8'd0, 8'd255, 8'd128,
                    8'd64, 8'd32, 8'd16, 8'd4, 8'd9, 8'd17, 8'd33, 8'd65,
                    8'd129, 8'd200, 8'd100, 8'd50, 8'd25, 8'd12, 8'd6, 8'd3};
        for (int i = 0; i < 512; i++) mem[i] = 9'd0;
        mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = 9'h003; mem[3] = 9'h004;
        mem[4] = 9'h1C3; mem[5] = 9'h005; mem[6] = 9'h006; mem[10] = 9'h00A;
        start_addr = 9'd0; done_addr = 9'd6;
        start = 1'b0; exec_done = 1'b0; cond_flag = 1'b0;

        //                st sa   ex cd  v  ni jf tg   run ad    ins
        tbl.push_back(mk(1, 9'd0, 0, 0,  0, 0, 0, 8'd0, 0, 9'd0,  9'h000)); // SYNC
        tbl.push_back(mk(0, 9'd0, 1, 0,  0, 0, 0, 8'd0, 1, 9'd0,  9'h000)); // FETCH
        tbl.push_back(mk(0, 9'd0, 1, 0,  1, 0, 0, 8'd0, 1, 9'd0,  9'h001));
        tbl.push_back(mk(0, 9'd0, 1, 1,  0, 1, 0, 8'd0, 1, 9'd0,  9'h001)); // non-branch, cond ignored
        tbl.push_back(mk(0, 9'd0, 1, 1,  0, 0, 0, 8'd0, 1, 9'd1,  9'h001));
        tbl.push_back(mk(0, 9'd0, 1, 0,  1, 0, 0, 8'd0, 1, 9'd1,  9'h002));
        tbl.push_back(mk(0, 9'd0, 1, 0,  0, 1, 0, 8'd0, 1, 9'd1,  9'h002));
        tbl.push_back(mk(0, 9'd0, 1, 0,  0, 0, 0, 8'd0, 1, 9'd2,  9'h002));
        tbl.push_back(mk(0, 9'd0, 1, 0,  1, 0, 0, 8'd0, 1, 9'd2,  9'h003));
        tbl.push_back(mk(0, 9'd0, 1, 0,  0, 1, 0, 8'd0, 1, 9'd2,  9'h003));
        tbl.push_back(mk(0, 9'd0, 1, 0,  0, 0, 0, 8'd0, 1, 9'd3,  9'h003));
        tbl.push_back(mk(0, 9'd0, 1, 0,  1, 0, 0, 8'd0, 1, 9'd3,  9'h004));
        tbl.push_back(mk(0, 9'd0, 1, 0,  0, 1, 0, 8'd0, 1, 9'd3,  9'h004));
        tbl.push_back(mk(0, 9'd0, 1, 0,  0, 0, 0, 8'd0, 1, 9'd4,  9'h004));
        tbl.push_back(mk(0, 9'd0, 1, 0,  1, 0, 0, 8'd0, 1, 9'd4,  9'h1C3));
        tbl.push_back(mk(0, 9'd0, 1, 1,  0, 1, 1, 8'd5, 1, 9'd4,  9'h1C3)); // taken branch
        tbl.push_back(mk(0, 9'd0, 0, 0,  0, 0, 0, 8'd0, 1, 9'd10, 9'h1C3)); // 4 -> 10
        tbl.push_back(mk(0, 9'd0, 0, 0,  1, 0, 0, 8'd0, 1, 9'd10, 9'h00A));
        for (int k = 0; k < 7; k++)                                          // stall
            tbl.push_back(mk(0, 9'd0, 0, 1, 1, 0, 0, 8'd0, 1, 9'd10, 9'h00A));
        tbl.push_back(mk(0, 9'd0, 1, 1,  0, 1, 0, 8'd0, 1, 9'd10, 9'h00A));
        tbl.push_back(mk(0, 9'd0, 1, 0,  0, 0, 0, 8'd0, 1, 9'd11, 9'h00A));
        tbl.push_back(mk(0, 9'd0, 0, 0,  1, 0, 0, 8'd0, 1, 9'd11, 9'h000));
        tbl.push_back(mk(1, 9'd4, 1, 1,  0, 0, 0, 8'd0, 1, 9'd4,  9'h000)); // start mid-ISSUE
        tbl.push_back(mk(0, 9'd0, 1, 0,  0, 0, 0, 8'd0, 1, 9'd4,  9'h000));
        tbl.push_back(mk(0, 9'd0, 1, 0,  1, 0, 0, 8'd0, 1, 9'd4,  9'h1C3));
        tbl.push_back(mk(0, 9'd0, 1, 0,  0, 1, 0, 8'd0, 1, 9'd4,  9'h1C3)); // not taken
        tbl.push_back(mk(0, 9'd0, 1, 0,  0, 0, 0, 8'd0, 1, 9'd5,  9'h1C3)); // 4 -> 5
        tbl.push_back(mk(0, 9'd0, 1, 0,  1, 0, 0, 8'd0, 1, 9'd5,  9'h005));
        tbl.push_back(mk(0, 9'd0, 1, 0,  0, 1, 0, 8'd0, 1, 9'd5,  9'h005));
        tbl.push_back(mk(0, 9'd0, 1, 0,  0, 0, 0, 8'd0, 1, 9'd6,  9'h005)); // FETCH at done
        tbl.push_back(mk(0, 9'd0, 1, 0,  0, 0, 0, 8'd0, 0, 9'd6,  9'h005)); // HALT, no latch
        tbl.push_back(mk(0, 9'd0, 1, 0,  0, 0, 0, 8'd0, 0, 9'd6,  9'h005));
        tbl.push_back(mk(1, 9'd0, 0, 0,  0, 0, 0, 8'd0, 0, 9'd0,  9'h005)); // restart
        tbl.push_back(mk(0, 9'd0, 1, 0,  0, 0, 0, 8'd0, 1, 9'd0,  9'h005));
        tbl.push_back(mk(0, 9'd0, 1, 0,  1, 0, 0, 8'd0, 1, 9'd0,  9'h001)); // ends in ISSUE

        reset_n = 1'b0;
        #12;
        check("reset valid", instr_valid, 1'b0);
        check("reset next_ins", next_ins, 1'b0);
        check("reset jump", jump_flag, 1'b0);
        check("reset target", target, 8'd0);
        check("reset running", running, 1'b0);
        check("reset instr", instr, 9'd0);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            start = tbl[i].st; start_addr = tbl[i].sa;
            exec_done = tbl[i].ex; cond_flag = tbl[i].cd;
            @(posedge clock); #1;
            check($sformatf("row%0d valid", i), instr_valid, tbl[i].v);
            check($sformatf("row%0d next_ins", i), next_ins, tbl[i].ni);
            check($sformatf("row%0d jump", i), jump_flag, tbl[i].jf);
            check($sformatf("row%0d target", i), target, tbl[i].tg);
            check($sformatf("row%0d running", i), running, tbl[i].run);
            check($sformatf("row%0d addr", i), imem_addr, tbl[i].ad);
            check($sformatf("row%0d instr", i), instr, tbl[i].ins);
        end

        // async reset while an instruction is being executed
        start = 1'b0; exec_done = 1'b1; cond_flag = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        check("midreset valid", instr_valid, 1'b0);
        check("midreset next_ins", next_ins, 1'b0);
        check("midreset running", running, 1'b0);
        check("midreset instr", instr, 9'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            check("post-reset idle valid", instr_valid, 1'b0);
            check("post-reset idle next_ins", next_ins, 1'b0);
            check("post-reset idle running", running, 1'b0);
        end

        // randomized programs against the instruction-level model
        for (int run = 0; run < 10; run++) begin
            for (int i = 0; i < 512; i++) begin
                mem[i] = 9'($urandom);
                if ($urandom_range(0, 2) == 0) mem[i][8:6] = 3'b111;
            end
            start_addr = 9'($urandom);
            done_addr  = start_addr + 9'($urandom_range(0, 30));
            arch_pc = start_addr;
            halted = 1'b0;
            start = 1'b1; exec_done = 1'($urandom); cond_flag = 1'($urandom);
            @(posedge clock); #1;
            start = 1'b0;
            check("rnd start next_ins", next_ins, 1'b0);
            check("rnd start valid", instr_valid, 1'b0);
            gap = 0;
            for (int cyc = 0; cyc < 400 && !halted; cyc++) begin
                exec_done = ($urandom_range(0, 2) != 0);
                cond_flag = 1'($urandom);
                exp_adv = instr_valid && exec_done;
                cur = mem[arch_pc];
                taken = (cur[8:6] == 3'b111) && cond_flag;
                tgt = taken ? lut_ref[cur[4:0]] : 8'd0;
                @(posedge clock); #1;
                if (gap >= 0) gap++;
                check("rnd next_ins", next_ins, exp_adv);
                if (exp_adv) begin
                    check("rnd jump", jump_flag, taken);
                    check("rnd target", target, tgt);
                    arch_pc = arch_pc + 9'd1 + {1'b0, tgt};
                    gap = 0;
                end else begin
                    check("rnd idle jump", jump_flag, 1'b0);
                    check("rnd idle target", target, 8'd0);
                end
                if (gap == 1) begin
                    check("rnd fetch valid", instr_valid, 1'b0);
                end else if (gap == 2) begin
                    if (arch_pc == done_addr) begin
                        check("rnd halt running", running, 1'b0);
                        check("rnd halt valid", instr_valid, 1'b0);
                        halted = 1'b1;
                    end else begin
                        check("rnd issue valid", instr_valid, 1'b1);
                        check("rnd issue instr", instr, mem[arch_pc]);
                    end
                    gap = -1;
                end else if (instr_valid) begin
                    check("rnd hold instr", instr, mem[arch_pc]);
                    check("rnd hold addr", imem_addr, arch_pc);
                end
            end
            if (halted) begin
                for (int k = 0; k < 3; k++) begin
                    exec_done = 1'b1;
                    @(posedge clock); #1;
                    check("rnd halted valid", instr_valid, 1'b0);
                    check("rnd halted next_ins", next_ins, 1'b0);
                    check("rnd halted running", running, 1'b0);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
